// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port among N_REQ L1 requesters, with
// write-invalidate broadcast. Define ARB_TIMEOUT_EN to enable the BUSY-state abort timer.
module l2_port_arbiter #(
    parameter int N_REQ   = 8,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_rd_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*32-1:0]     req_din,
    output logic [N_REQ-1:0]        req_page_wr,
    output logic [127:0]            req_page_dout,
    output logic [N_REQ-1:0]        req_wr_ack,
    output logic [N_REQ-1:0]        req_dirty,
    output logic [ADDR_W-1:0]       req_dirty_addr,
    output logic                    l2_valid,
    output logic                    l2_rd_wr,
    output logic [ADDR_W-1:0]       l2_addr,
    output logic [31:0]             l2_din,
    input  logic                    l2_page_wr,
    input  logic [127:0]            l2_page_dout,
    input  logic                    l2_wr_ack,
    output logic                    arb_err
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  rr_ptr, g, win, g_inc;
    logic              win_found, mask_last, lat_rd_wr, rsp_match, timeout_hit;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_din;
    logic [127:0]      page_q;
    logic [N_REQ-1:0]  g_onehot, cand;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s -= N_REQ;
        return IDX_W'(s);
    endfunction

    assign g_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << g;
    assign g_inc     = wrap_idx(g, 1);
    assign rsp_match = lat_rd_wr ? l2_wr_ack : l2_page_wr;

    // The requester just served is excluded for one IDLE cycle so a slow
    // deassert of its request level cannot win it a second grant.
    always_comb begin
        win       = rr_ptr;
        win_found = 1'b0;
        cand      = req_valid & ~(mask_last ? g_onehot : '0);
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && cand[wrap_idx(rr_ptr, i)]) begin
                win       = wrap_idx(rr_ptr, i);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        l2_valid       = 1'b0;
        req_page_wr    = '0;
        req_wr_ack     = '0;
        req_dirty      = '0;
        req_dirty_addr = '0;
        case (state)
            IDLE: if (win_found) state_next = BUSY;
            BUSY: begin
                l2_valid = 1'b1;
                if (rsp_match)        state_next = DONE;
                else if (timeout_hit) state_next = IDLE;
            end
            DONE: begin
                state_next = IDLE;
                if (lat_rd_wr) begin
                    req_wr_ack     = g_onehot;
                    req_dirty      = ~g_onehot;
                    req_dirty_addr = lat_addr;
                end else begin
                    req_page_wr    = g_onehot;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            g         <= '0;
            mask_last <= 1'b0;
            lat_rd_wr <= 1'b0;
            lat_addr  <= '0;
            lat_din   <= '0;
            page_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    if (win_found) begin
                        g         <= win;
                        lat_rd_wr <= req_rd_wr[win];
                        lat_addr  <= req_addr[win*ADDR_W +: ADDR_W];
                        lat_din   <= req_din[win*32 +: 32];
                    end
                end
                BUSY: begin
                    if (rsp_match && !lat_rd_wr) page_q <= l2_page_dout;
                    if (!rsp_match && timeout_hit) rr_ptr <= g_inc;
                end
                DONE: begin
                    rr_ptr    <= g_inc;
                    mask_last <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       arb_err_q;

    // Counter sits at zero outside BUSY, so it is already clear on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= timeout_hit;
            if (state == BUSY) to_cnt <= to_cnt + 8'd1;
            else               to_cnt <= '0;
        end
    end

    assign timeout_hit = (state == BUSY) && !rsp_match && (to_cnt == 8'(TIMEOUT - 1));
    assign arb_err     = arb_err_q;
`else
    assign timeout_hit = 1'b0;
    assign arb_err     = 1'b0;
`endif

    assign l2_rd_wr      = lat_rd_wr;
    assign l2_addr       = lat_addr;
    assign l2_din        = lat_din;
    assign req_page_dout = page_q;

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Shares the single L2 cache port between all L1 caches in the cluster. With 4 cores, each having a data and an instruction L1, that is 8 requesters. Round-robin arbitration grants one requester at a time and carries its read/write to L2. The line-fill pulse or write-ack pulse is returned to the granted requester only. After every completed write, a dirty/invalidate pulse with the written address goes to all other requesters. The block sits between the core_master instances and the shared L2.

Parameters:
N_REQ, 8, number of requesters; index = core*2 + (0 data, 1 inst)
ADDR_W, 14, L2 word address width
TIMEOUT, 255, cycles allowed in BUSY before abort (only used with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester request level; held until its completion pulse
req_rd_wr  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
req_din  in  N_REQ*32  flattened write data
req_page_wr  out  N_REQ  one-cycle line-fill pulse to the granted reader
req_page_dout  out  128  registered line data, valid with req_page_wr
req_wr_ack  out  N_REQ  one-cycle write-done pulse to the granted writer
req_dirty  out  N_REQ  one-cycle invalidate pulse to every non-granted requester
req_dirty_addr  out  ADDR_W  address carried with req_dirty
l2_valid  out  1  request level to L2
l2_rd_wr  out  1  latched request type
l2_addr  out  ADDR_W  latched address
l2_din  out  32  latched write data
l2_page_wr  in  1  L2 read complete; line on l2_page_dout
l2_page_dout  in  128  line data
l2_wr_ack  in  1  L2 write complete
arb_err  out  1  one-cycle abort pulse (only with ARB_TIMEOUT_EN; tied to 0 otherwise)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rr_ptr=0; grant index g=0; mask_last=0.
  - All outputs 0, including l2_*, req_* and arb_err.
- State IDLE:
  - Candidates are req_valid, with bit g removed when mask_last=1. Clear mask_last after this cycle.
  - Winner is the first set candidate searching rr_ptr, rr_ptr+1, … mod N_REQ.
  - If a winner exists: latch g, rd_wr, addr and din; go to BUSY.
  - If none: stay in IDLE.
- State BUSY:
  - Drive l2_valid=1 with the latched fields, held stable.
  - Exit only on the matching response: l2_page_wr when latched rd_wr=0, l2_wr_ack when rd_wr=1.
  - The non-matching response is ignored.
  - On exit, register l2_page_dout and go to DONE.
- State DONE (exactly 1 cycle):
  - l2_valid=0.
  - Read: req_page_wr[g]=1 and req_page_dout = captured line.
  - Write: req_wr_ack[g]=1, req_dirty[i]=1 for all i≠g, req_dirty_addr = latched addr.
  - Then rr_ptr=(g+1) mod N_REQ, mask_last=1, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 gives l2_valid at cycle 1.
  - L2 response at cycle k gives the completion pulse at cycle k+1.
  - Earliest next grant is at cycle k+2.
- Other rules:
  - req_page_dout holds its last value between fills.
  - Reads never produce req_dirty.
  - Responses arriving in IDLE or DONE are ignored.
  - If req_valid[g] drops during BUSY, the transaction still completes and the pulse is still delivered.
  - Changes to other requesters' inputs never affect the latched fields.
  - Reset mid-BUSY: l2_valid drops immediately, no pulse is delivered, and rr_ptr returns to 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no matching response, arb_err pulses for 1 cycle and l2_valid drops.
  - No page_wr, wr_ack or dirty pulse is issued; rr_ptr=(g+1) mod N_REQ; go to IDLE.
- Undefined: no counter; BUSY waits indefinitely; arb_err is constant 0.

Test Plan:
- Single read: req_valid[2]=1, rd_wr=0, addr=0x0123 → l2_valid at cycle 1 with l2_addr=0x0123. L2 gives page_wr with 0xDEAD…BEEF at cycle 5 → req_page_wr[2] and that data at cycle 6; no req_dirty.
- Write broadcast: req_valid[4]=1, rd_wr=1, addr=0x0040, din=0x12345678 → l2_din=0x12345678. wr_ack → req_wr_ack[4]=1; req_dirty=8'b1110_1111 with req_dirty_addr=0x0040.
- Round-robin: all 8 valid, each L2 response after 2 cycles → grant order 0,1,…,7,0; no requester is granted twice while others wait.
- Mask: requester 3 keeps req_valid high one cycle after its pulse while requester 5 is valid → next grant is 5, not 3.
- Wrong response: BUSY on a read, L2 pulses l2_wr_ack → stays in BUSY, l2_valid stays 1, no pulses; a later l2_page_wr completes normally.
- Reset/timeout: rst low during BUSY → all outputs 0 the same cycle. With ARB_TIMEOUT_EN and TIMEOUT=16 and a silent L2 → arb_err after 16 BUSY cycles, then the next requester is granted.
